// File: rtl/timing_budget_sequencer_pkg.sv
// Shared sensor definitions: sequence-config bit map, overhead constants, FSM/step encodings.
package timing_budget_sequencer_pkg;

   // sequence_config bit positions
   localparam int unsigned CfgMsrcBit  = 2;
   localparam int unsigned CfgDssBit   = 3;
   localparam int unsigned CfgTccBit   = 4;
   localparam int unsigned CfgPreBit   = 6;
   localparam int unsigned CfgFinalBit = 7;

   // Fixed timing overheads in microseconds
   localparam logic [31:0] StartOvhUs = 32'd1910;
   localparam logic [31:0] EndOvhUs   = 32'd960;
   localparam logic [31:0] TccOvhUs   = 32'd590;
   localparam logic [31:0] DssOvhUs   = 32'd690;
   localparam logic [31:0] MsrcOvhUs  = 32'd660;
   localparam logic [31:0] PreOvhUs   = 32'd660;
   localparam logic [31:0] FinalOvhUs = 32'd550;

   typedef enum logic [2:0] {
      StIdle,
      StNext,
      StIssue,
      StWait,
      StSum,
      StDone
   } seq_state_e;

   typedef enum logic [1:0] {
      StepMsrc,
      StepPre,
      StepFinal,
      StepNone
   } step_e;

   typedef struct packed {
      logic tcc;
      logic dss;
      logic msrc;
      logic pre;
      logic fin;
   } seq_en_t;

   function automatic seq_en_t decode_config(input logic [7:0] cfg);
      seq_en_t en;
      en.tcc  = cfg[CfgTccBit];
      en.dss  = cfg[CfgDssBit];
      en.msrc = cfg[CfgMsrcBit];
      en.pre  = cfg[CfgPreBit];
      en.fin  = cfg[CfgFinalBit];
      return en;
   endfunction

   // Pending-step bit for a step: bit0 MSRC, bit1 PRE, bit2 FINAL
   function automatic logic [2:0] step_mask(input step_e step);
      logic [2:0] m;
      case (step)
         StepMsrc:  m = 3'b001;
         StepPre:   m = 3'b010;
         StepFinal: m = 3'b100;
         default:   m = 3'b000;
      endcase
      return m;
   endfunction

   // Final-range timeout includes pre-range; strip it out, never going negative
   function automatic logic [15:0] final_operand(input logic [15:0] final_mclks,
                                                 input logic [15:0] pre_mclks,
                                                 input logic        pre_en);
      logic [15:0] r;
      if (!pre_en) begin
         r = final_mclks;
      end else if (final_mclks > pre_mclks) begin
         r = final_mclks - pre_mclks;
      end else begin
         r = '0;
      end
      return r;
   endfunction

endpackage

// File: rtl/timing_budget_sequencer_if.sv
// Start/done handshake to the shared mclk->us timeout converter.
interface timing_budget_sequencer_if;

   logic        conv_start;
   logic [15:0] conv_mclks;
   logic [7:0]  conv_vcsel;
   logic        conv_done;
   logic [31:0] conv_us;

   // Requester side (the sequencer)
   modport master (
      output conv_start,
      output conv_mclks,
      output conv_vcsel,
      input  conv_done,
      input  conv_us
   );

   // Converter side
   modport slave (
      input  conv_start,
      input  conv_mclks,
      input  conv_vcsel,
      output conv_done,
      output conv_us
   );

endinterface

// File: rtl/timing_budget_sequencer.sv
// Measurement timing budget sequencer: runs the needed timeout conversions (MSRC, PRE, FINAL)
// through an external converter, then sums step times with the enabled fixed overheads.
module timing_budget_sequencer
   import timing_budget_sequencer_pkg::*;
#(
   parameter int unsigned CONV_TIMEOUT_CYCLES = 64,
   parameter logic [31:0] START_OVERHEAD_US   = StartOvhUs,
   parameter logic [31:0] END_OVERHEAD_US     = EndOvhUs,
   parameter logic [31:0] TCC_OVH             = TccOvhUs,
   parameter logic [31:0] DSS_OVH             = DssOvhUs,
   parameter logic [31:0] MSRC_OVH            = MsrcOvhUs,
   parameter logic [31:0] PRE_OVH             = PreOvhUs,
   parameter logic [31:0] FINAL_OVH           = FinalOvhUs
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   output logic                              busy,
   output logic                              done,
   output logic                              error,
   input  logic [7:0]                        sequence_config,
   input  logic [15:0]                       msrc_mclks,
   input  logic [15:0]                       pre_range_mclks,
   input  logic [15:0]                       final_range_mclks,
   input  logic [7:0]                        pre_vcsel_pclks,
   input  logic [7:0]                        final_vcsel_pclks,
   timing_budget_sequencer_if.master         conv,
   output logic [31:0]                       budget_us
);

   localparam int unsigned WdogW = $clog2(CONV_TIMEOUT_CYCLES + 1);

   seq_state_e  state_q, state_d;
   seq_en_t     en_q, en_d;
   step_e       step_q, step_d;
   logic [2:0]  pending_q, pending_d;
   logic [15:0] msrc_mclks_q, msrc_mclks_d;
   logic [15:0] pre_mclks_q, pre_mclks_d;
   logic [15:0] final_mclks_q, final_mclks_d;
   logic [7:0]  pre_vcsel_q, pre_vcsel_d;
   logic [7:0]  final_vcsel_q, final_vcsel_d;
   logic [31:0] msrc_us_q, msrc_us_d;
   logic [31:0] pre_us_q, pre_us_d;
   logic [31:0] final_us_q, final_us_d;
   logic [WdogW-1:0] wdog_q, wdog_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        error_q, error_d;
   logic        conv_start_q, conv_start_d;
   logic [15:0] conv_mclks_q, conv_mclks_d;
   logic [7:0]  conv_vcsel_q, conv_vcsel_d;
   logic [31:0] budget_q, budget_d;

   step_e       sel_step;
   logic [15:0] iss_mclks;
   logic [7:0]  iss_vcsel;
   logic [31:0] acc;
   logic [WdogW-1:0] wdog_inc;
   logic        advance;

   // Bits 0, 1 and 5 of sequence_config do not affect the budget
   logic unused_cfg;
   assign unused_cfg = ^{sequence_config[5], sequence_config[1:0]};

   assign wdog_inc = wdog_q + WdogW'(1);

   // Pick the first still-pending step in MSRC, PRE, FINAL order
   always_comb begin
      sel_step = StepNone;
      if (pending_q[0]) begin
         sel_step = StepMsrc;
      end else if (pending_q[1]) begin
         sel_step = StepPre;
      end else if (pending_q[2]) begin
         sel_step = StepFinal;
      end
   end

   // Converter operands for the selected step
   always_comb begin
      iss_mclks = '0;
      iss_vcsel = '0;
      case (sel_step)
         StepMsrc: begin
            iss_mclks = msrc_mclks_q;
            iss_vcsel = pre_vcsel_q;
         end
         StepPre: begin
            iss_mclks = pre_mclks_q;
            iss_vcsel = pre_vcsel_q;
         end
         StepFinal: begin
            iss_mclks = final_operand(final_mclks_q, pre_mclks_q, en_q.pre);
            iss_vcsel = final_vcsel_q;
         end
         default: ;
      endcase
   end

   // Budget accumulation from latched step times; DSS replaces the plain MSRC term
   always_comb begin
      acc = START_OVERHEAD_US + END_OVERHEAD_US;
      if (en_q.tcc) begin
         acc = acc + msrc_us_q + TCC_OVH;
      end
      if (en_q.dss) begin
         acc = acc + ((msrc_us_q + DSS_OVH) << 1);
      end else if (en_q.msrc) begin
         acc = acc + msrc_us_q + MSRC_OVH;
      end
      if (en_q.pre) begin
         acc = acc + pre_us_q + PRE_OVH;
      end
      if (en_q.fin) begin
         acc = acc + final_us_q + FINAL_OVH;
      end
   end

   // Next-state logic for the sequencer FSM and all registered outputs
   always_comb begin
      state_d       = state_q;
      en_d          = en_q;
      step_d        = step_q;
      pending_d     = pending_q;
      msrc_mclks_d  = msrc_mclks_q;
      pre_mclks_d   = pre_mclks_q;
      final_mclks_d = final_mclks_q;
      pre_vcsel_d   = pre_vcsel_q;
      final_vcsel_d = final_vcsel_q;
      msrc_us_d     = msrc_us_q;
      pre_us_d      = pre_us_q;
      final_us_d    = final_us_q;
      wdog_d        = wdog_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      error_d       = error_q;
      conv_start_d  = 1'b0;
      conv_mclks_d  = conv_mclks_q;
      conv_vcsel_d  = conv_vcsel_q;
      budget_d      = budget_q;
      advance       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               en_d          = decode_config(sequence_config);
               pending_d     = {en_d.fin, en_d.pre, en_d.tcc | en_d.dss | en_d.msrc};
               msrc_mclks_d  = msrc_mclks;
               pre_mclks_d   = pre_range_mclks;
               final_mclks_d = final_range_mclks;
               pre_vcsel_d   = pre_vcsel_pclks;
               final_vcsel_d = final_vcsel_pclks;
               error_d       = 1'b0;
               budget_d      = '0;
               busy_d        = 1'b1;
               state_d       = StNext;
            end
         end
         StNext: begin
            advance = 1'b1;
         end
         StIssue: begin
            state_d = StWait;
         end
         StWait: begin
            if (conv.conv_done) begin
               case (step_q)
                  StepMsrc:  msrc_us_d  = conv.conv_us;
                  StepPre:   pre_us_d   = conv.conv_us;
                  StepFinal: final_us_d = conv.conv_us;
                  default: ;
               endcase
               advance = 1'b1;
            end else if (wdog_inc == WdogW'(CONV_TIMEOUT_CYCLES)) begin
               error_d  = 1'b1;
               budget_d = '0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               state_d  = StDone;
            end else begin
               wdog_d = wdog_inc;
            end
         end
         StSum: begin
            budget_d = acc;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            state_d  = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Launch the next pending conversion, or go sum once none remain
      if (advance) begin
         if (sel_step == StepNone) begin
            state_d = StSum;
         end else begin
            state_d      = StIssue;
            step_d       = sel_step;
            pending_d    = pending_q & ~step_mask(sel_step);
            conv_start_d = 1'b1;
            conv_mclks_d = iss_mclks;
            conv_vcsel_d = iss_vcsel;
            wdog_d       = '0;
         end
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         en_q          <= '0;
         step_q        <= StepNone;
         pending_q     <= '0;
         msrc_mclks_q  <= '0;
         pre_mclks_q   <= '0;
         final_mclks_q <= '0;
         pre_vcsel_q   <= '0;
         final_vcsel_q <= '0;
         msrc_us_q     <= '0;
         pre_us_q      <= '0;
         final_us_q    <= '0;
         wdog_q        <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         error_q       <= 1'b0;
         conv_start_q  <= 1'b0;
         conv_mclks_q  <= '0;
         conv_vcsel_q  <= '0;
         budget_q      <= '0;
      end else begin
         state_q       <= state_d;
         en_q          <= en_d;
         step_q        <= step_d;
         pending_q     <= pending_d;
         msrc_mclks_q  <= msrc_mclks_d;
         pre_mclks_q   <= pre_mclks_d;
         final_mclks_q <= final_mclks_d;
         pre_vcsel_q   <= pre_vcsel_d;
         final_vcsel_q <= final_vcsel_d;
         msrc_us_q     <= msrc_us_d;
         pre_us_q      <= pre_us_d;
         final_us_q    <= final_us_d;
         wdog_q        <= wdog_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         error_q       <= error_d;
         conv_start_q  <= conv_start_d;
         conv_mclks_q  <= conv_mclks_d;
         conv_vcsel_q  <= conv_vcsel_d;
         budget_q      <= budget_d;
      end
   end

   assign busy            = busy_q;
   assign done            = done_q;
   assign error           = error_q;
   assign budget_us       = budget_q;
   assign conv.conv_start = conv_start_q;
   assign conv.conv_mclks = conv_mclks_q;
   assign conv.conv_vcsel = conv_vcsel_q;

endmodule
